// File: rtl/qdec_pkg.sv
// Shared phase encodings and direction constants for the quadrature decoder.
// Imported by sync_bit and quad_decoder.
package qdec_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer chain for one asynchronous input bit.
// All flops reset asynchronously to 0.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the async input through the flop chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// x4 quadrature decoder: sync, optional glitch filter, decode, counter.
// Define QDEC_GLITCH_FILTER_EN to insert the per-phase glitch filter.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] ONE = 1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("FILT_LEN must be at least 1");
  end

  phase_t raw;
  phase_t cur;
  phase_t prev;
  logic   primed;
  logic   mv_up;
  logic   mv_dn;
  logic   mv_bad;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .d     (a_in),
    .q     (raw[1])
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .d     (b_in),
    .q     (raw[0])
  );

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FLAST = FW'(FILT_LEN - 1);
  localparam logic [FW-1:0] FONE = 1;

  phase_t        flt;
  logic [FW-1:0] fcnt [2];

  // accept a new level only after FILT_LEN equal samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flt     <= '0;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == flt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLAST) begin
          flt[i]  <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FONE;
        end
      end
    end
  end

  assign cur = flt;
`else
  assign cur = raw;
`endif

  // classify the prev -> cur phase transition
  always_comb begin
    mv_up  = 1'b0;
    mv_dn  = 1'b0;
    mv_bad = 1'b0;
    unique case ({prev, cur})
      {PH_00, PH_01}, {PH_01, PH_11},
      {PH_11, PH_10}, {PH_10, PH_00}: mv_up = 1'b1;
      {PH_00, PH_10}, {PH_10, PH_11},
      {PH_11, PH_01}, {PH_01, PH_00}: mv_dn = 1'b1;
      {PH_00, PH_11}, {PH_11, PH_00},
      {PH_01, PH_10}, {PH_10, PH_01}: mv_bad = 1'b1;
      default: ;
    endcase
  end

  // priming, counter, direction and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev   <= PH_00;
      primed <= 1'b0;
      count  <= '0;
      dir    <= DIR_UP;
      step   <= 1'b0;
      err    <= 1'b0;
      wrap   <= 1'b0;
    end else if (clr) begin
      primed <= 1'b0;
      count  <= '0;
      step   <= 1'b0;
      err    <= 1'b0;
      wrap   <= 1'b0;
    end else if (!primed) begin
      prev   <= cur;
      primed <= 1'b1;
      step   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      prev <= cur;
      step <= 1'b0;
      wrap <= 1'b0;
      if (mv_bad) begin
        err <= 1'b1;
      end
      if (en && mv_up) begin
        count <= count + ONE;
        dir   <= DIR_UP;
        step  <= 1'b1;
        wrap  <= &count;
      end else if (en && mv_dn) begin
        count <= count - ONE;
        dir   <= DIR_DN;
        step  <= 1'b1;
        wrap  <= ~|count;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder.
// Inputs change on negedge; outputs sampled on negedge.
module tb_quad_decoder;
  import qdec_pkg::*;

`ifdef QDEC_GLITCH_FILTER_EN
  localparam int LAT = 2 + 3 + 1;
`else
  localparam int LAT = 2 + 1;
`endif

  logic       clk;
  logic       reset;
  logic       a_in;
  logic       b_in;
  logic       en;
  logic       clr;
  logic [7:0] count;
  logic       dir;
  logic       step;
  logic       err;
  logic       wrap;

  int checks;
  int errors;
  int nsteps;
  int base;
  logic pre_step;
  logic got_step;
  logic got_wrap;

  quad_decoder #(
    .CNT_W       (8),
    .SYNC_STAGES (2),
    .FILT_LEN    (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .a_in  (a_in),
    .b_in  (b_in),
    .en    (en),
    .clr   (clr),
    .count (count),
    .dir   (dir),
    .step  (step),
    .err   (err),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step === 1'b1) nsteps <= nsteps + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive a phase, sample just before and just after the update edge
  task automatic apply(input phase_t ph);
    a_in = ph[1];
    b_in = ph[0];
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    pre_step = step;
    @(negedge clk);
    got_step = step;
    got_wrap = wrap;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nsteps = 0;
    reset  = 1'b1;
    a_in   = 1'b0;
    b_in   = 1'b0;
    en     = 1'b1;
    clr    = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);

    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("prime_step", 32'(step), 32'd0);

    apply(PH_01); apply(PH_11);
    apply(PH_10); apply(PH_00);
    apply(PH_01); apply(PH_11);
    apply(PH_10); apply(PH_00);
    chk("up8_count", 32'(count), 32'd8);
    chk("up8_dir", 32'(dir), 32'd1);
    chk("up8_steps", 32'(nsteps), 32'd8);
    chk("up8_err", 32'(err), 32'd0);

    apply(PH_10);
    chk("dn1_pre", 32'(pre_step), 32'd0);
    chk("dn1_step", 32'(got_step), 32'd1);
    apply(PH_11);
    chk("dn2_pre", 32'(pre_step), 32'd0);
    chk("dn2_step", 32'(got_step), 32'd1);
    apply(PH_01);
    chk("dn3_pre", 32'(pre_step), 32'd0);
    chk("dn3_step", 32'(got_step), 32'd1);
    chk("dn3_count", 32'(count), 32'd5);
    chk("dn3_dir", 32'(dir), 32'd0);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr0_count", 32'(count), 32'd0);

    apply(PH_00);
    chk("dnwrap_count", 32'(count), 32'd255);
    chk("dnwrap_wrap", 32'(got_wrap), 32'd1);
    chk("dnwrap_pulse", 32'(wrap), 32'd0);

    apply(PH_01);
    chk("upwrap_count", 32'(count), 32'd0);
    chk("upwrap_wrap", 32'(got_wrap), 32'd1);
    chk("upwrap_dir", 32'(dir), 32'd1);

    apply(PH_11); apply(PH_10); apply(PH_00);
    chk("pre_jump_count", 32'(count), 32'd3);
    base = nsteps;
    apply(PH_11);
    chk("jump_err", 32'(err), 32'd1);
    chk("jump_step", 32'(got_step), 32'd0);
    chk("jump_count", 32'(count), 32'd3);
    chk("jump_dir", 32'(dir), 32'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_step", 32'(step), 32'd0);
    @(negedge clk);
    chk("reprime_step", 32'(step), 32'd0);
    chk("reprime_err", 32'(err), 32'd0);
    repeat (3) @(negedge clk);
    chk("clr_nsteps", 32'(nsteps - base), 32'd0);

    en = 1'b0;
    apply(PH_10); apply(PH_00);
    apply(PH_01); apply(PH_11);
    chk("en0_count", 32'(count), 32'd0);
    chk("en0_steps", 32'(nsteps - base), 32'd0);
    chk("en0_err", 32'(err), 32'd0);
    en = 1'b1;
    apply(PH_10);
    chk("en1_count", 32'(count), 32'd1);
    chk("en1_step", 32'(got_step), 32'd1);

`ifdef QDEC_GLITCH_FILTER_EN
    base = nsteps;
    a_in = 1'b0;
    repeat (2) @(negedge clk);
    a_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_steps", 32'(nsteps - base), 32'd0);
    chk("glitch_err", 32'(err), 32'd0);
    chk("glitch_count", 32'(count), 32'd1);
`endif

    reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_dir", 32'(dir), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
